// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet MII transmit framer.
package eth_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPreamble,
    StSfd,
    StDa,
    StSa,
    StLength,
    StData,
    StPad,
    StIfg
  } txStateT;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;
  localparam int unsigned DA_BYTES  = 6;
  localparam int unsigned SA_BYTES  = 6;
  localparam int unsigned LEN_BYTES = 2;

endpackage

// File: rtl/eth_txnibsel.sv
// Nibble selector: picks the nibble to drive for a given field, byte index and nibble phase.
module eth_txnibsel
  import eth_pkg::*;
(
  input  txStateT     state,
  input  logic [2:0]  byteIdx,
  input  logic        nibCnt,
  input  logic [47:0] da,
  input  logic [47:0] sa,
  input  logic [15:0] len,
  input  logic [7:0]  dataByte,
  output logic [3:0]  nib
);

  logic [47:0] daSh;
  logic [47:0] saSh;
  logic [7:0]  byteV;

  always_comb begin
    // Addresses go out most-significant byte first.
    daSh  = da << {byteIdx, 3'b000};
    saSh  = sa << {byteIdx, 3'b000};
    byteV = '0;
    unique case (state)
      StDa:     byteV = daSh[47:40];
      StSa:     byteV = saSh[47:40];
      StLength: byteV = byteIdx[0] ? len[7:0] : len[15:8];
      StData:   byteV = dataByte;
      default:  byteV = '0;
    endcase
    nib = nibCnt ? byteV[7:4] : byteV[3:0];
    if (state == StPreamble) begin
      nib = PREAMBLE_NIB;
    end else if (state == StSfd) begin
      nib = nibCnt ? SFD_NIB : PREAMBLE_NIB;
    end
  end

endmodule

// File: rtl/eth_txframer.sv
// Nibble-wide MII transmit framer: preamble, SFD, DA, SA, Length/Type, payload, zero pad, IFG.
module eth_txframer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIBS = 14,
  parameter int unsigned IFG_NIBS      = 24,
  parameter int unsigned MIN_DATA      = 46,
  parameter int unsigned MAX_DATA      = 1500
) (
  input  logic        MRxClk,
  input  logic        Resetn,
  input  logic        No_Preamble,
  input  logic        TxStartFrm,
  input  logic [47:0] DA,
  input  logic [47:0] SA,
  input  logic [15:0] Length,
  input  logic [7:0]  TxData,
  input  logic        TxDataValid,
  input  logic        TxEndFrm,
  output logic        TxDataRd,
  output logic [3:0]  MTxD,
  output logic        MTxEn,
  output logic        TxBusy,
  output logic        TxDone,
  output logic        TxAbort,
  output logic        StateIdle,
  output logic        StatePreamble,
  output logic        StateSFD,
  output logic        StateDA,
  output logic        StateSA,
  output logic        StateLength,
  output logic        StateData,
  output logic        StatePad,
  output logic        StateIFG
);

  txStateT     state_q, state_d;
  logic        nibCnt_q, nibCnt_d;
  logic [15:0] byteCnt_q, byteCnt_d, lastByte;
  logic [10:0] dataCnt_q, dataCnt_d;
  logic [47:0] daL_q, saL_q;
  logic [15:0] lenL_q;
  logic [7:0]  dataByte_q, dataByte_d;
  logic        endSeen_q, endSeen_d;
  logic        fieldDone, done_d, abort_d, mtxEn_d;
  logic [3:0]  nibNext;

  assign lastByte = (state_q == StPreamble) ? 16'(PREAMBLE_NIBS / 2 - 1) :
                    (state_q == StDa)       ? 16'(DA_BYTES - 1) :
                    (state_q == StSa)       ? 16'(SA_BYTES - 1) :
                    (state_q == StLength)   ? 16'(LEN_BYTES - 1) : 16'd0;
  assign fieldDone = nibCnt_q && (byteCnt_q == lastByte);

  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      nibCnt_q   <= 1'b0;
      byteCnt_q  <= '0;
      dataCnt_q  <= '0;
      daL_q      <= '0;
      saL_q      <= '0;
      lenL_q     <= '0;
      dataByte_q <= '0;
      endSeen_q  <= 1'b0;
      MTxD       <= 4'h0;
      MTxEn      <= 1'b0;
      TxDone     <= 1'b0;
      TxAbort    <= 1'b0;
    end else begin
      state_q    <= state_d;
      nibCnt_q   <= nibCnt_d;
      byteCnt_q  <= byteCnt_d;
      dataCnt_q  <= dataCnt_d;
      dataByte_q <= dataByte_d;
      endSeen_q  <= endSeen_d;
      if (state_q == StIdle && TxStartFrm) begin
        daL_q  <= DA;
        saL_q  <= SA;
        lenL_q <= Length;
      end
      MTxEn   <= mtxEn_d;
      MTxD    <= mtxEn_d ? nibNext : 4'h0;
      TxDone  <= done_d;
      TxAbort <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nibCnt_d   = nibCnt_q;
    byteCnt_d  = byteCnt_q;
    dataCnt_d  = dataCnt_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    endSeen_d  = (state_q == StIdle) ? 1'b0 : endSeen_q;
    dataByte_d = dataByte_q;
    if (state_q inside {StPreamble, StSfd, StDa, StSa, StLength, StData, StPad}) begin
      nibCnt_d = ~nibCnt_q;
      if (nibCnt_q) byteCnt_d = byteCnt_q + 16'd1;
    end
    unique case (state_q)
      StIdle: if (TxStartFrm) begin
        state_d   = No_Preamble ? StSfd : StPreamble;
        dataCnt_d = '0;
      end
      StPreamble: if (fieldDone) state_d = StSfd;
      StSfd:      if (fieldDone) state_d = StDa;
      StDa:       if (fieldDone) state_d = StSa;
      StSa:       if (fieldDone) state_d = StLength;
      StLength:   if (fieldDone) state_d = StData;
      StData: if (nibCnt_q) begin
        if (endSeen_q) begin
          if (dataCnt_q < 11'(MIN_DATA)) begin
            state_d = StPad;
          end else begin
            state_d = StIfg;
            done_d  = 1'b1;
          end
        end else if (dataCnt_q == 11'(MAX_DATA)) begin
          state_d = StIfg;
          abort_d = 1'b1;
        end
      end
      StPad: if (nibCnt_q) begin
        dataCnt_d = dataCnt_q + 11'd1;
        if (dataCnt_q == 11'(MIN_DATA - 1)) begin
          state_d = StIfg;
          done_d  = 1'b1;
        end
      end
      StIfg: begin
        byteCnt_d = byteCnt_q + 16'd1;
        if (byteCnt_q == 16'(IFG_NIBS - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A fetch with no data available overrides any other outcome.
    if (TxDataRd) begin
      if (!TxDataValid) begin
        state_d = StIfg;
        abort_d = 1'b1;
      end else begin
        dataCnt_d  = dataCnt_q + 11'd1;
        dataByte_d = TxData;
        if (TxEndFrm) endSeen_d = 1'b1;
      end
    end
    if (state_d != state_q) begin
      byteCnt_d = '0;
      nibCnt_d  = 1'b0;
    end
  end

  always_comb begin
    TxDataRd = (state_q == StLength && fieldDone) ||
               (state_q == StData && nibCnt_q && !endSeen_q &&
                dataCnt_q != 11'(MAX_DATA));
    mtxEn_d       = !(state_d inside {StIdle, StIfg});
    TxBusy        = (state_q != StIdle);
    StateIdle     = (state_q == StIdle);
    StatePreamble = (state_q == StPreamble);
    StateSFD      = (state_q == StSfd);
    StateDA       = (state_q == StDa);
    StateSA       = (state_q == StSa);
    StateLength   = (state_q == StLength);
    StateData     = (state_q == StData);
    StatePad      = (state_q == StPad);
    StateIFG      = (state_q == StIfg);
  end

  // Selects from next-cycle values so the registered nibble lines up with the state.
  eth_txnibsel u_nibsel (
    .state    (state_d),
    .byteIdx  (byteCnt_d[2:0]),
    .nibCnt   (nibCnt_d),
    .da       (daL_q),
    .sa       (saL_q),
    .len      (lenL_q),
    .dataByte (dataByte_d),
    .nib      (nibNext)
  );

endmodule

// File: tb/tb_eth_txframer.sv
// Directed bench for eth_txframer with a nibble scoreboard fed at frame start.
module tb_eth_txframer;

  logic        MRxClk, Resetn, No_Preamble, TxStartFrm;
  logic [47:0] DA, SA;
  logic [15:0] Length;
  logic [7:0]  TxData;
  logic        TxDataValid, TxEndFrm, TxDataRd;
  logic [3:0]  MTxD;
  logic        MTxEn, TxBusy, TxDone, TxAbort;
  logic        StateIdle, StatePreamble, StateSFD, StateDA, StateSA;
  logic        StateLength, StateData, StatePad, StateIFG;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] expQ[$];

  eth_txframer dut (
    .MRxClk        (MRxClk),
    .Resetn        (Resetn),
    .No_Preamble   (No_Preamble),
    .TxStartFrm    (TxStartFrm),
    .DA            (DA),
    .SA            (SA),
    .Length        (Length),
    .TxData        (TxData),
    .TxDataValid   (TxDataValid),
    .TxEndFrm      (TxEndFrm),
    .TxDataRd      (TxDataRd),
    .MTxD          (MTxD),
    .MTxEn         (MTxEn),
    .TxBusy        (TxBusy),
    .TxDone        (TxDone),
    .TxAbort       (TxAbort),
    .StateIdle     (StateIdle),
    .StatePreamble (StatePreamble),
    .StateSFD      (StateSFD),
    .StateDA       (StateDA),
    .StateSA       (StateSA),
    .StateLength   (StateLength),
    .StateData     (StateData),
    .StatePad      (StatePad),
    .StateIFG      (StateIFG)
  );

  initial MRxClk = 1'b0;
  always #5 MRxClk = ~MRxClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic pushByte(input logic [7:0] b);
    expQ.push_back(b[3:0]);
    expQ.push_back(b[7:4]);
  endtask

  // dropAt < 0: never underrun; neverEnd: TxEndFrm never asserted.
  task automatic runFrame(input int n, input bit noPre, input int dropAt, input bit neverEnd,
                          input bit pokeIfg);
    int idx, enCyc, doneCnt, abortCnt, bothCnt, padCyc, rdCnt, ifgCyc, sent, pads;
    bit rdPrev, aborted;
    idx = 0; enCyc = 0; doneCnt = 0; abortCnt = 0; bothCnt = 0;
    padCyc = 0; rdCnt = 0; ifgCyc = 0; rdPrev = 1'b0;
    aborted = (dropAt >= 0) || neverEnd;
    sent = (dropAt >= 0) ? dropAt : (neverEnd ? 1500 : n);
    pads = (!aborted && n < 46) ? 46 - n : 0;
    expQ.delete();
    if (!noPre) for (int i = 0; i < 14; i++) expQ.push_back(4'h5);
    expQ.push_back(4'h5);
    expQ.push_back(4'hD);
    for (int b = 0; b < 6; b++) pushByte(8'(DA >> (8 * (5 - b))));
    for (int b = 0; b < 6; b++) pushByte(8'(SA >> (8 * (5 - b))));
    pushByte(Length[15:8]);
    pushByte(Length[7:0]);
    for (int i = 0; i < sent; i++) pushByte(pay(i));
    for (int i = 0; i < pads; i++) pushByte(8'h00);

    No_Preamble = noPre;
    TxStartFrm  = 1'b1;
    @(posedge MRxClk); #1;
    TxStartFrm = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rdPrev) idx++;
      TxData      = pay(idx);
      TxDataValid = (idx != dropAt);
      TxEndFrm    = !neverEnd && (idx == n - 1);
      rdPrev = TxDataRd;
      if (TxDataRd) rdCnt++;
      if (MTxEn) begin
        enCyc++;
        if (expQ.size() > 0) chk("nibble", MTxD, expQ.pop_front());
        else chk("extra nibble", expQ.size(), 1);
      end
      if (StatePad) padCyc++;
      if (TxDone) doneCnt++;
      if (TxDone && TxAbort) bothCnt++;
      if (TxAbort) begin
        abortCnt++;
        chk("abort MTxEn", MTxEn, 0);
        chk("abort in IFG", StateIFG, 1);
      end
      if (TxBusy && !MTxEn) ifgCyc++;
      if (pokeIfg) TxStartFrm = StateIFG && ifgCyc >= 2 && ifgCyc < 6;
      if (!TxBusy) break;
      @(posedge MRxClk); #1;
    end
    TxStartFrm = 1'b0;
    chk("frame timeout", TxBusy, 0);
    chk("MTxEn cycles", enCyc, (noPre ? 0 : 14) + 2 + 28 + 2 * (sent + pads));
    chk("queue drained", expQ.size(), 0);
    chk("TxDone count", doneCnt, aborted ? 0 : 1);
    chk("TxAbort count", abortCnt, aborted ? 1 : 0);
    chk("done and abort", bothCnt, 0);
    chk("IFG cycles", ifgCyc, 24);
    chk("pad cycles", padCyc, 2 * pads);
    chk("fetch count", rdCnt, (dropAt >= 0) ? dropAt + 1 : (neverEnd ? 1500 : n));
    if (pokeIfg) begin
      repeat (3) @(posedge MRxClk);
      #1;
      chk("start in IFG ignored", TxBusy, 0);
    end
  endtask

  initial begin
    Resetn = 1'b0; No_Preamble = 1'b0; TxStartFrm = 1'b0;
    DA = 48'h112233445566; SA = 48'hAABBCCDDEEFF; Length = 16'h003C;
    TxData = '0; TxDataValid = 1'b0; TxEndFrm = 1'b0;
    #1;
    chk("reset MTxEn", MTxEn, 0);
    chk("reset MTxD", MTxD, 0);
    chk("reset idle", StateIdle, 1);
    chk("reset busy", TxBusy, 0);
    #21 Resetn = 1'b1;
    @(posedge MRxClk); #1;

    runFrame(60, 1'b0, -1, 1'b0, 1'b1);
    DA = 48'h0123456789AB; SA = 48'h5A5AC3C30F0F; Length = 16'h0800;
    runFrame(10, 1'b0, -1, 1'b0, 1'b0);
    runFrame(46, 1'b1, -1, 1'b0, 1'b0);
    runFrame(20, 1'b0, 4, 1'b0, 1'b0);
    runFrame(1, 1'b0, -1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the DA field.
    TxStartFrm = 1'b1;
    @(posedge MRxClk); #1;
    TxStartFrm = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (StateDA) break;
      @(posedge MRxClk); #1;
    end
    chk("reached DA", StateDA, 1);
    chk("DA MTxEn", MTxEn, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("midframe reset MTxEn", MTxEn, 0);
    chk("midframe reset idle", StateIdle, 1);
    chk("midframe reset busy", TxBusy, 0);
    @(negedge MRxClk);
    Resetn = 1'b1;
    @(posedge MRxClk); #1;
    chk("idle after reset", StateIdle, 1);

    runFrame(50, 1'b0, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
